// File: rtl/booth_r4_seq_mult_if.sv
// Start/busy/done multiplier bus between operand regs and result bus.
// master drives start/sgn/operands; slave returns busy/done/product.
interface booth_r4_seq_mult_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic               sgn;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, sgn, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, sgn, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth multiplier, one digit per clock.
// Ports: clk, rst_n (async low), bus (slave: start/sgn/A/B in, busy/done/product out).
module booth_r4_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  booth_r4_seq_mult_if.slave bus
);
  localparam int W  = WIDTH;
  localparam int HW = W + 2;
  localparam int CW = $clog2(W/2 + 2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_nx;
  logic [HW-1:0]   a_q;
  logic [HW-1:0]   hi_q;
  logic [HW-1:0]   y_q;
  logic            ym1_q;
  logic            sgn_q;
  logic [CW-1:0]   cnt_q;
  logic            accept;
  logic            last;

  logic [2:0]      grp;
  logic [HW:0]     a_x;
  logic [HW:0]     addend;
  logic [HW:0]     sum;
  logic [HW-1:0]   hi_nx;
  logic [HW-1:0]   y_nx;
  logic [2*W-1:0]  prod_nx;
  logic [HW-1:0]   a_ext;
  logic [HW-1:0]   b_ext;

  assign accept = (state == IDLE) && bus.start;
  assign last   = (state == RUN) &&
                  (cnt_q == (sgn_q ? CW'(W/2 - 1) : CW'(W/2)));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (last)      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  assign a_ext = bus.sgn ? {{2{bus.multiplicand[W-1]}}, bus.multiplicand}
                         : {2'b00, bus.multiplicand};
  assign b_ext = bus.sgn ? {{2{bus.multiplier[W-1]}}, bus.multiplier}
                         : {2'b00, bus.multiplier};

  assign grp = {y_q[1:0], ym1_q};
  assign a_x = {a_q[HW-1], a_q};

  always_comb begin
    addend = '0;
    unique case (1'b1)
      (grp == 3'b001 || grp == 3'b010): addend = a_x;
      (grp == 3'b011):                  addend = a_x << 1;
      (grp == 3'b100):                  addend = -(a_x << 1);
      (grp == 3'b101 || grp == 3'b110): addend = -a_x;
      default:                          addend = '0;
    endcase
  end

  // One guard bit above hi: |hi + 2A| can exceed the W+2 range in
  // unsigned mode, so the shift takes its sign from the wider sum.
  assign sum   = {hi_q[HW-1], hi_q} + addend;
  assign hi_nx = {sum[HW], sum[HW:2]};
  assign y_nx  = {sum[1:0], y_q[HW-1:2]};

  // After k shifts the top 2k bits of y hold the product's low bits.
  assign prod_nx = sgn_q ? {hi_nx[W-1:0], y_nx[HW-1:2]}
                         : {hi_nx[W-3:0], y_nx};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      hi_q        <= '0;
      y_q         <= '0;
      ym1_q       <= 1'b0;
      sgn_q       <= 1'b0;
      cnt_q       <= '0;
      bus.done    <= 1'b0;
      bus.product <= '0;
    end else begin
      bus.done <= last;
      if (accept) begin
        a_q   <= a_ext;
        y_q   <= b_ext;
        hi_q  <= '0;
        ym1_q <= 1'b0;
        sgn_q <= bus.sgn;
        cnt_q <= '0;
      end else if (state == RUN) begin
        hi_q  <= hi_nx;
        y_q   <= y_nx;
        ym1_q <= y_q[1];
        cnt_q <= cnt_q + CW'(1);
        if (last) bus.product <= prod_nx;
      end
    end
  end

  assign bus.busy = (state == RUN);
endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Bench for booth_r4_seq_mult at W=8 and W=16.
// Directed corners, handshake cases, then random ops vs A*B model.
module tb_booth_r4_seq_mult;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  booth_r4_seq_mult_if #(.WIDTH(8))  b8();
  booth_r4_seq_mult_if #(.WIDTH(16)) b16();

  booth_r4_seq_mult #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .bus(b8)
  );
  booth_r4_seq_mult #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .bus(b16)
  );

  int errors = 0;
  int checks = 0;
  logic [15:0] last8;
  logic [31:0] last16;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref8(input logic s,
                                       input logic [7:0] a, b);
    longint p;
    if (s) p = longint'($signed(a)) * longint'($signed(b));
    else   p = longint'(a) * longint'(b);
    return p[15:0];
  endfunction

  function automatic logic [31:0] ref16(input logic s,
                                        input logic [15:0] a, b);
    longint p;
    if (s) p = longint'($signed(a)) * longint'($signed(b));
    else   p = longint'(a) * longint'(b);
    return p[31:0];
  endfunction

  function automatic logic [7:0] pick8();
    logic [7:0] c [4] = '{8'h00, 8'hFF, 8'h80, 8'h7F};
    if ($urandom_range(0, 7) == 0) return c[$urandom_range(0, 3)];
    return 8'($urandom);
  endfunction

  function automatic logic [15:0] pick16();
    logic [15:0] c [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
    if ($urandom_range(0, 7) == 0) return c[$urandom_range(0, 3)];
    return 16'($urandom);
  endfunction

  task automatic go8(input logic s, input logic [7:0] a, b,
                     input string tag, input bit now);
    int n;
    int j;
    logic [15:0] e;
    n = s ? 4 : 5;
    e = ref8(s, a, b);
    if (!now) @(negedge clk);
    b8.start = 1'b1;
    b8.sgn = s;
    b8.multiplicand = a;
    b8.multiplier = b;
    @(negedge clk);
    b8.start = 1'b0;
    b8.sgn = ~s;
    b8.multiplicand = ~a;
    b8.multiplier = ~b;
    check({tag, ".busy"}, 64'(b8.busy), 64'd1);
    j = 0;
    while (!b8.done && j < 20) begin
      if (j == 1) check({tag, ".hold"}, 64'(b8.product), 64'(last8));
      @(negedge clk);
      j++;
    end
    check({tag, ".lat"}, 64'(j), 64'(n));
    check({tag, ".prod"}, 64'(b8.product), 64'(e));
    check({tag, ".idle"}, 64'(b8.busy), 64'd0);
    last8 = e;
  endtask

  task automatic par(input logic s8, input logic [7:0] a8, b8v,
                     input logic s16, input logic [15:0] a16, b16v,
                     input string tag);
    int j;
    int g8;
    int g16;
    logic [15:0] e8;
    logic [31:0] e16;
    e8 = ref8(s8, a8, b8v);
    e16 = ref16(s16, a16, b16v);
    @(negedge clk);
    b8.start = 1'b1;
    b8.sgn = s8;
    b8.multiplicand = a8;
    b8.multiplier = b8v;
    b16.start = 1'b1;
    b16.sgn = s16;
    b16.multiplicand = a16;
    b16.multiplier = b16v;
    @(negedge clk);
    b8.start = 1'b0;
    b16.start = 1'b0;
    j = 0;
    g8 = -1;
    g16 = -1;
    while ((g8 < 0 || g16 < 0) && j < 30) begin
      @(negedge clk);
      j++;
      if (b8.done && g8 < 0) begin
        g8 = j;
        check({tag, ".p8"}, 64'(b8.product), 64'(e8));
      end
      if (b16.done && g16 < 0) begin
        g16 = j;
        check({tag, ".p16"}, 64'(b16.product), 64'(e16));
      end
    end
    check({tag, ".lat8"}, 64'(g8), 64'(s8 ? 4 : 5));
    check({tag, ".lat16"}, 64'(g16), 64'(s16 ? 8 : 9));
    last8 = e8;
    last16 = e16;
  endtask

  initial begin
    int cnt;
    int first;
    logic [15:0] e;
    b8.start = 1'b0;
    b8.sgn = 1'b0;
    b8.multiplicand = '0;
    b8.multiplier = '0;
    b16.start = 1'b0;
    b16.sgn = 1'b0;
    b16.multiplicand = '0;
    b16.multiplier = '0;
    last8 = '0;
    last16 = '0;

    repeat (2) @(negedge clk);
    check("rst.busy8", 64'(b8.busy), 64'd0);
    check("rst.done8", 64'(b8.done), 64'd0);
    check("rst.prod8", 64'(b8.product), 64'd0);
    check("rst.busy16", 64'(b16.busy), 64'd0);
    check("rst.done16", 64'(b16.done), 64'd0);
    check("rst.prod16", 64'(b16.product), 64'd0);
    rst_n = 1'b1;

    go8(1'b1, 8'd12, 8'd1, "s12x1", 1'b0);
    go8(1'b1, 8'h80, 8'h80, "smin2", 1'b0);
    go8(1'b1, 8'hFF, 8'h7F, "sm1x127", 1'b0);
    go8(1'b0, 8'hFF, 8'hFF, "umax2", 1'b0);
    go8(1'b0, 8'd0, 8'd0, "b2b.u0", 1'b1);
    go8(1'b1, 8'd0, 8'h55, "b2b.s0", 1'b1);
    go8(1'b1, 8'h81, 8'h7F, "smix", 1'b0);

    e = ref8(1'b1, 8'd7, 8'hFD);
    @(negedge clk);
    b8.start = 1'b1;
    b8.sgn = 1'b1;
    b8.multiplicand = 8'd7;
    b8.multiplier = 8'hFD;
    @(negedge clk);
    b8.start = 1'b0;
    cnt = 0;
    first = -1;
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      if (j == 2) begin
        b8.start = 1'b1;
        b8.sgn = 1'b0;
        b8.multiplicand = 8'hAA;
        b8.multiplier = 8'h33;
      end else begin
        b8.start = 1'b0;
      end
      if (b8.done) begin
        cnt++;
        if (first < 0) begin
          first = j;
          check("ign.prod", 64'(b8.product), 64'(e));
        end
      end
    end
    check("ign.first", 64'(first), 64'd4);
    check("ign.count", 64'(cnt), 64'd1);
    check("ign.hold", 64'(b8.product), 64'(e));

    @(negedge clk);
    b8.start = 1'b1;
    b8.sgn = 1'b0;
    b8.multiplicand = 8'd200;
    b8.multiplier = 8'd100;
    @(negedge clk);
    b8.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst.busy", 64'(b8.busy), 64'd0);
    check("arst.done", 64'(b8.done), 64'd0);
    check("arst.prod", 64'(b8.product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (b8.done) cnt++;
    end
    check("arst.nodone", 64'(cnt), 64'd0);
    check("arst.prod2", 64'(b8.product), 64'd0);
    last8 = '0;
    last16 = '0;

    par(1'b1, 8'h80, 8'h80, 1'b1, 16'h8000, 16'h8000, "smin");
    par(1'b0, 8'hFF, 8'hFF, 1'b0, 16'hFFFF, 16'hFFFF, "umax");
    par(1'b1, 8'h7F, 8'h80, 1'b1, 16'h7FFF, 16'h8000, "sedge");

    for (int i = 0; i < 3000; i++) begin
      par(1'($urandom), pick8(), pick8(),
          1'($urandom), pick16(), pick16(), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end
endmodule
